id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Latches decoded instruction fields and operands from decode and presents them to execute.
- Execute includes the forwarding unit; this block supplies its source indices and the EX-stage destination, write-back and mem-read information.
- Inserts a one-cycle bubble on load-use dependencies, freezes on memory stall, squashes on flush and counts bubbles.

Parameters:
- DATA_W, 16, operand/immediate width.
- ALU_OP_W, 4, ALU opcode width.
- BUB_CNT_W, 16, width of saturating bubble counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rsrc1  in  3  source register 1 index.
- id_rsrc2  in  3  source register 2 index.
- id_uses_src1  in  1  instruction reads rsrc1.
- id_uses_src2  in  1  instruction reads rsrc2.
- id_rdst  in  3  destination register index.
- id_wb  in  1  writes register file.
- id_mem_read  in  1  load.
- id_mem_write  in  1  store.
- id_alu_op  in  ALU_OP_W  ALU operation.
- id_data1  in  DATA_W  register-file read 1.
- id_data2  in  DATA_W  register-file read 2.
- id_imm  in  DATA_W  immediate.
- flush  in  1  squash instruction entering EX (taken branch/jump).
- mem_stall  in  1  memory stage busy; freeze.
- ex_valid  out  1  EX holds a real instruction.
- ex_rsrc1, ex_rsrc2, ex_rdst  out  3 each  registered indices.
- ex_wb, ex_mem_read, ex_mem_write  out  1 each  registered controls.
- ex_alu_op  out  ALU_OP_W  registered opcode.
- ex_data1, ex_data2, ex_imm  out  DATA_W each  registered operands.
- stall_fetch  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_count  out  BUB_CNT_W  load-use bubbles inserted.

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs and bubble_count go to 0. stall_fetch is 0 while rst is asserted.
- hazard (combinational) = ex_valid & ex_mem_read & ex_wb & id_valid & ((id_uses_src1 & id_rsrc1==ex_rdst) | (id_uses_src2 & id_rsrc2==ex_rdst)).
- Per-edge priority: rst > mem_stall > flush > hazard > normal.
- mem_stall=1:
  - Every ex_* register holds its value.
  - bubble_count holds.
  - stall_fetch=1.
  - flush and hazard are ignored this cycle. The flush source holds flush until mem_stall drops.
- flush=1 (no mem_stall):
  - Load a bubble: ex_valid, ex_wb, ex_mem_read, ex_mem_write = 0; all indices, opcode and data = 0.
  - stall_fetch=0.
  - bubble_count unchanged.
- hazard=1 (no mem_stall, no flush):
  - Load a bubble.
  - stall_fetch=1, so decode re-presents the same instruction next cycle.
  - bubble_count += 1, saturating at all-ones.
  - The bubble clears ex_mem_read, so the hazard cannot persist beyond one cycle: exactly one bubble per load-use.
- Normal: capture all id_* fields. ex_valid = id_valid.
  - An id_valid=0 input is captured as a bubble with controls forced to 0.
  - Data is captured as-is.
- Latency: one cycle from id_* to ex_*.
- stall_fetch = ~rst & (mem_stall | (hazard & ~flush)).
- Register index 0 is an ordinary register; no special-casing.
- A store whose data source depends on a preceding load stalls like any other source use.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all ex_* = 0, bubble_count = 0, stall_fetch = 0.
- Load-use: load R3 (mem_read=1, wb=1, rdst=3) enters EX; next decode is ADD with rsrc1=3, uses_src1=1.
  - Required: stall_fetch=1 for one cycle, then ex_valid=0 bubble, then the ADD enters EX with ex_rsrc1=3.
  - bubble_count=1.
- No false stall:
  - Non-load ALU op writing R3 followed by a reader of R3 -> no stall; relies on forwarding.
  - Load R3 followed by an instruction with rsrc1=3 but uses_src1=0 -> no stall.
- Freeze: hold mem_stall=1 for 3 cycles with the load-use condition present.
  - Required: ex_* unchanged for 3 cycles, stall_fetch=1 throughout, bubble_count unchanged.
  - Required after release: exactly one bubble.
- Flush vs hazard same cycle: flush=1 and hazard=1.
  - Required: bubble loaded, stall_fetch=0, bubble_count unchanged.
- Saturation: BUB_CNT_W=2, trigger 5 load-use pairs -> bubble_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, memory-stall freeze,
// flush squash and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ALU_OP_W  = 4,
    parameter int unsigned BUB_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [2:0]           id_rsrc1,
    input  logic [2:0]           id_rsrc2,
    input  logic                 id_uses_src1,
    input  logic                 id_uses_src2,
    input  logic [2:0]           id_rdst,
    input  logic                 id_wb,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic [DATA_W-1:0]    id_data1,
    input  logic [DATA_W-1:0]    id_data2,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic                 ex_valid,
    output logic [2:0]           ex_rsrc1,
    output logic [2:0]           ex_rsrc2,
    output logic [2:0]           ex_rdst,
    output logic                 ex_wb,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic [DATA_W-1:0]    ex_data1,
    output logic [DATA_W-1:0]    ex_data2,
    output logic [DATA_W-1:0]    ex_imm,
    output logic                 stall_fetch,
    output logic [BUB_CNT_W-1:0] bubble_count
);

    logic                 valid_q, valid_d;
    logic [2:0]           rsrc1_q, rsrc1_d;
    logic [2:0]           rsrc2_q, rsrc2_d;
    logic [2:0]           rdst_q, rdst_d;
    logic                 wb_q, wb_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ALU_OP_W-1:0]  alu_op_q, alu_op_d;
    logic [DATA_W-1:0]    data1_q, data1_d;
    logic [DATA_W-1:0]    data2_q, data2_d;
    logic [DATA_W-1:0]    imm_q, imm_d;
    logic [BUB_CNT_W-1:0] bubble_count_q, bubble_count_d;
    logic                 hazard;

    // Only a load that also writes back can create a load-use dependency.
    always_comb begin
        hazard = valid_q & mem_read_q & wb_q & id_valid &
                 ((id_uses_src1 & (id_rsrc1 == rdst_q)) |
                  (id_uses_src2 & (id_rsrc2 == rdst_q)));
    end

    always_comb begin
        valid_d        = valid_q;
        rsrc1_d        = rsrc1_q;
        rsrc2_d        = rsrc2_q;
        rdst_d         = rdst_q;
        wb_d           = wb_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        alu_op_d       = alu_op_q;
        data1_d        = data1_q;
        data2_d        = data2_q;
        imm_d          = imm_q;
        bubble_count_d = bubble_count_q;
        if (mem_stall) begin
            // Freeze: everything holds; flush and hazard wait for release.
        end else if (flush || hazard) begin
            valid_d     = 1'b0;
            rsrc1_d     = '0;
            rsrc2_d     = '0;
            rdst_d      = '0;
            wb_d        = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            alu_op_d    = '0;
            data1_d     = '0;
            data2_d     = '0;
            imm_d       = '0;
            if (!flush && hazard && (bubble_count_q != '1)) begin
                bubble_count_d = bubble_count_q + BUB_CNT_W'(1);
            end
        end else begin
            valid_d     = id_valid;
            rsrc1_d     = id_rsrc1;
            rsrc2_d     = id_rsrc2;
            rdst_d      = id_rdst;
            wb_d        = id_valid & id_wb;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
            alu_op_d    = id_alu_op;
            data1_d     = id_data1;
            data2_d     = id_data2;
            imm_d       = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            rsrc1_q        <= '0;
            rsrc2_q        <= '0;
            rdst_q         <= '0;
            wb_q           <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            alu_op_q       <= '0;
            data1_q        <= '0;
            data2_q        <= '0;
            imm_q          <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            rsrc1_q        <= rsrc1_d;
            rsrc2_q        <= rsrc2_d;
            rdst_q         <= rdst_d;
            wb_q           <= wb_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            alu_op_q       <= alu_op_d;
            data1_q        <= data1_d;
            data2_q        <= data2_d;
            imm_q          <= imm_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    always_comb begin
        stall_fetch  = ~rst & (mem_stall | (hazard & ~flush));
        ex_valid     = valid_q;
        ex_rsrc1     = rsrc1_q;
        ex_rsrc2     = rsrc2_q;
        ex_rdst      = rdst_q;
        ex_wb        = wb_q;
        ex_mem_read  = mem_read_q;
        ex_mem_write = mem_write_q;
        ex_alu_op    = alu_op_q;
        ex_data1     = data1_q;
        ex_data2     = data2_q;
        ex_imm       = imm_q;
        bubble_count = bubble_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubble, false-stall cases,
// memory-stall freeze, flush priority and counter saturation (2-bit instance).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_src1, id_uses_src2;
    logic [2:0]  id_rsrc1, id_rsrc2, id_rdst;
    logic        id_wb, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_op;
    logic [15:0] id_data1, id_data2, id_imm;
    logic        flush, mem_stall;

    logic        ex_valid, ex_wb, ex_mem_read, ex_mem_write, stall_fetch;
    logic [2:0]  ex_rsrc1, ex_rsrc2, ex_rdst;
    logic [3:0]  ex_alu_op;
    logic [15:0] ex_data1, ex_data2, ex_imm, bubble_count;

    logic        s_valid, s_wb, s_mem_read, s_mem_write, s_stall_fetch;
    logic [2:0]  s_rsrc1, s_rsrc2, s_rdst;
    logic [3:0]  s_alu_op;
    logic [15:0] s_data1, s_data2, s_imm;
    logic [1:0]  s_bubble_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(16), .ALU_OP_W(4), .BUB_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_rdst(id_rdst),
        .id_wb(id_wb), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_op(id_alu_op), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .flush(flush), .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_rsrc1(ex_rsrc1),
        .ex_rsrc2(ex_rsrc2), .ex_rdst(ex_rdst), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op), .ex_data1(ex_data1),
        .ex_data2(ex_data2), .ex_imm(ex_imm), .stall_fetch(stall_fetch),
        .bubble_count(bubble_count)
    );

    id_ex_stage #(.DATA_W(16), .ALU_OP_W(4), .BUB_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_rdst(id_rdst),
        .id_wb(id_wb), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_op(id_alu_op), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .flush(flush), .mem_stall(mem_stall), .ex_valid(s_valid), .ex_rsrc1(s_rsrc1),
        .ex_rsrc2(s_rsrc2), .ex_rdst(s_rdst), .ex_wb(s_wb), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_alu_op(s_alu_op), .ex_data1(s_data1),
        .ex_data2(s_data2), .ex_imm(s_imm), .stall_fetch(s_stall_fetch),
        .bubble_count(s_bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                         input logic wb, input logic mr, input logic mw, input logic [3:0] op,
                         input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm);
        id_valid = v;  id_rsrc1 = rs1; id_uses_src1 = u1; id_rsrc2 = rs2; id_uses_src2 = u2;
        id_rdst = rd;  id_wb = wb; id_mem_read = mr; id_mem_write = mw; id_alu_op = op;
        id_data1 = d1; id_data2 = d2; id_imm = imm;
        #1;
    endtask

    task automatic load_r3(input logic [15:0] d1);
        drive(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 1, 0, 4'd1, d1, 16'h0, 16'h0004);
    endtask

    initial begin
        #2;
        // Reset with random inputs and mem_stall high; stall_fetch must stay low.
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b1;
        drive(1, 3'($urandom), 1, 3'($urandom), 1, 3'($urandom), 1, 1, 1,
              4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        chk("rst_stall_fetch_comb", {31'b0, stall_fetch}, 0);
        tick();
        drive(1, 3'($urandom), 1, 3'($urandom), 1, 3'($urandom), 1, 1, 1,
              4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        tick();
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_ex_wb", {31'b0, ex_wb}, 0);
        chk("rst_ex_mem_read", {31'b0, ex_mem_read}, 0);
        chk("rst_ex_rdst", {29'b0, ex_rdst}, 0);
        chk("rst_ex_data1", {16'b0, ex_data1}, 0);
        chk("rst_ex_imm", {16'b0, ex_imm}, 0);
        chk("rst_bubble_count", {16'b0, bubble_count}, 0);
        chk("rst_stall_fetch", {31'b0, stall_fetch}, 0);
        rst = 1'b0; mem_stall = 1'b0;

        // Load-use on rsrc1: one stall cycle, one bubble, then the ADD.
        load_r3(16'h1111);
        chk("lu_no_stall_on_load", {31'b0, stall_fetch}, 0);
        tick();
        chk("lu_load_valid", {31'b0, ex_valid}, 1);
        chk("lu_load_mem_read", {31'b0, ex_mem_read}, 1);
        chk("lu_load_rdst", {29'b0, ex_rdst}, 3);
        chk("lu_load_data1", {16'b0, ex_data1}, 32'h1111);
        drive(1, 3'd3, 1, 3'd2, 1, 3'd4, 1, 0, 0, 4'd2, 16'h2222, 16'h3333, 16'h0);
        chk("lu_stall_fetch", {31'b0, stall_fetch}, 1);
        tick();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 0);
        chk("lu_bubble_mem_read", {31'b0, ex_mem_read}, 0);
        chk("lu_bubble_data1", {16'b0, ex_data1}, 0);
        chk("lu_bubble_count", {16'b0, bubble_count}, 1);
        chk("lu_stall_released", {31'b0, stall_fetch}, 0);
        tick();
        chk("lu_add_valid", {31'b0, ex_valid}, 1);
        chk("lu_add_rsrc1", {29'b0, ex_rsrc1}, 3);
        chk("lu_add_alu_op", {28'b0, ex_alu_op}, 2);
        chk("lu_add_data2", {16'b0, ex_data2}, 32'h3333);
        chk("lu_count_after", {16'b0, bubble_count}, 1);

        // ALU producer of R3 followed by a reader: forwarding, no stall.
        drive(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 4'd5, 16'h0, 16'h0, 16'h0);
        tick();
        drive(1, 3'd3, 1, 3'd3, 1, 3'd6, 1, 0, 0, 4'd2, 16'hAAAA, 16'h0, 16'h0);
        chk("alu_no_stall", {31'b0, stall_fetch}, 0);
        tick();
        chk("alu_reader_valid", {31'b0, ex_valid}, 1);
        chk("alu_reader_data1", {16'b0, ex_data1}, 32'hAAAA);

        // Load R3 then rsrc1=3 with uses_src1=0: no stall.
        load_r3(16'h0);
        tick();
        drive(1, 3'd3, 0, 3'd5, 1, 3'd6, 1, 0, 0, 4'd2, 16'hBBBB, 16'h0, 16'h0);
        chk("unused_src_no_stall", {31'b0, stall_fetch}, 0);
        tick();
        chk("unused_src_valid", {31'b0, ex_valid}, 1);
        chk("unused_src_count", {16'b0, bubble_count}, 1);

        // Freeze three cycles with a store depending on the load via rsrc2.
        load_r3(16'h4444);
        tick();
        drive(1, 3'd1, 1, 3'd3, 1, 3'd0, 0, 0, 1, 4'd0, 16'h0, 16'hCCCC, 16'h8);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_stall_fetch", {31'b0, stall_fetch}, 1);
            tick();
            chk("frz_mem_read", {31'b0, ex_mem_read}, 1);
            chk("frz_data1", {16'b0, ex_data1}, 32'h4444);
            chk("frz_count", {16'b0, bubble_count}, 1);
        end
        mem_stall = 1'b0;
        #1;
        chk("frz_release_stall", {31'b0, stall_fetch}, 1);
        tick();
        chk("frz_bubble_valid", {31'b0, ex_valid}, 0);
        chk("frz_bubble_count", {16'b0, bubble_count}, 2);
        chk("frz_stall_after_bubble", {31'b0, stall_fetch}, 0);
        tick();
        chk("store_valid", {31'b0, ex_valid}, 1);
        chk("store_mem_write", {31'b0, ex_mem_write}, 1);
        chk("store_rsrc2", {29'b0, ex_rsrc2}, 3);
        chk("store_count", {16'b0, bubble_count}, 2);

        // Flush and hazard together: bubble, no fetch stall, count unchanged.
        load_r3(16'h0);
        tick();
        drive(1, 3'd3, 1, 3'd2, 0, 3'd5, 1, 0, 0, 4'd7, 16'h7777, 16'h0, 16'h0);
        flush = 1'b1;
        #1;
        chk("flush_stall_fetch", {31'b0, stall_fetch}, 0);
        tick();
        chk("flush_valid", {31'b0, ex_valid}, 0);
        chk("flush_rdst", {29'b0, ex_rdst}, 0);
        chk("flush_wb", {31'b0, ex_wb}, 0);
        chk("flush_count", {16'b0, bubble_count}, 2);
        flush = 1'b0;

        // id_valid=0 is captured with controls forced low, data as-is.
        drive(0, 3'd1, 1, 3'd2, 1, 3'd6, 1, 1, 1, 4'd3, 16'h5555, 16'h0, 16'h0);
        tick();
        chk("inv_valid", {31'b0, ex_valid}, 0);
        chk("inv_wb", {31'b0, ex_wb}, 0);
        chk("inv_mem_read", {31'b0, ex_mem_read}, 0);
        chk("inv_mem_write", {31'b0, ex_mem_write}, 0);
        chk("inv_data1", {16'b0, ex_data1}, 32'h5555);

        // Saturation on the 2-bit counter: 1, 2, 3, 3, 3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_r3(16'h0);
            tick();
            drive(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0, 4'd2, 16'h0, 16'h0, 16'h0);
            tick();
            chk("sat_count", {30'b0, s_bubble_count}, (k < 3) ? k + 1 : 3);
            chk("wide_count", {16'b0, bubble_count}, k + 1);
            tick();
            chk("sat_reader_valid", {31'b0, s_valid}, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
